// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : uart_pkg
//  Description : Shared types and timing helpers for the debugger UART path.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Word-assembly states: nothing held / partial word held
   typedef enum logic {
      RX_IDLE    = 1'b0,
      RX_COLLECT = 1'b1
   } rx_asm_state_t;

   // clk cycles per serial bit, clk given in MHz
   function automatic int clks_per_bit(input int clk_mhz, input int baud);
      return (clk_mhz * 1_000_000) / baud;
   endfunction

   // clk cycles in a timeout of 'ms' milliseconds, clk given in MHz
   function automatic int timeout_clks(input int clk_mhz, input int ms);
      return clk_mhz * ms * 1000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 byte receiver. Synchronises the serial input, samples
//                mid-bit and pulses dv_o for one cycle per received byte.
//                The stop bit is not checked; the byte is reported anyway.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic       dv_o,
   output logic [7:0] byte_o
);

   localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [1:0]    sync_q;
   logic [1:0]    state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    shift_q;
   logic          dv_q;
   logic          w_rx;

   assign w_rx   = sync_q[1];
   assign dv_o   = dv_q;
   assign byte_o = shift_q;

   // Two-flop synchroniser; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], rx_i};
   end

   // Bit-timing state machine: start-bit qualify, 8 data bits LSB first, stop
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         dv_q    <= 1'b0;
      end else begin
         dv_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (!w_rx) state_q <= ST_START;
            end
            ST_START: begin
               if (cnt_q == HALF) begin
                  cnt_q   <= '0;
                  bit_q   <= '0;
                  state_q <= w_rx ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            ST_DATA: begin
               if (cnt_q == FULL) begin
                  cnt_q   <= '0;
                  shift_q <= {w_rx, shift_q[7:1]};
                  if (bit_q == 3'd7) state_q <= ST_STOP;
                  else               bit_q   <= bit_q + 3'd1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               if (cnt_q == FULL) begin
                  cnt_q   <= '0;
                  dv_q    <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Synchronous first-word-fall-through FIFO with occupancy
//                count. Head data, valid and count are all registered.
//                A push while full is accepted only if a pop happens too.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             push_data_i,
   input  logic                         pop_i,
   output logic                         valid_o,
   output logic [WIDTH-1:0]             data_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic                         full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q, valid_d;
   logic             w_do_pop, w_do_push;

   assign full_o    = (count_q == CW'(DEPTH));
   assign w_do_pop  = pop_i && (count_q != '0);
   assign w_do_push = push_i && (!full_o || w_do_pop);

   assign valid_o = valid_q;
   assign data_o  = head_q;
   assign count_o = count_q;

   // Next pointers/count, and the word that will sit at the head next cycle
   always_comb begin
      rd_ptr_d = rd_ptr_q + PW'(w_do_pop);
      wr_ptr_d = wr_ptr_q + PW'(w_do_push);
      count_d  = count_q + CW'(w_do_push) - CW'(w_do_pop);
      valid_d  = (count_d != '0);
      if (count_d == '0)
         head_d = '0;
      else if (w_do_push && (wr_ptr_q == rd_ptr_d))
         head_d = push_data_i;  // new word lands straight at the head
      else
         head_d = mem_q[rd_ptr_d];
   end

   // Storage array; contents only matter for occupied slots, so no reset
   always_ff @(posedge clk) begin
      if (w_do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   // Pointer, count and head-register update
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= valid_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_packet.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_packet
//  Description : Serial-to-word receiver for the debugger link. Packs
//                WORD_BYTES UART bytes into a word (either byte order),
//                drops stale partial words after an inter-byte timeout, and
//                buffers finished words in a valid/ready FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_packet
   import uart_pkg::*;
#(
   parameter int CLK_RATE   = -1,
   parameter int BAUD       = 115200,
   parameter int IB_TIMEOUT = 200,
   parameter int WORD_BYTES = 4,
   parameter int BIG_ENDIAN = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              srx,
   output logic                              word_valid,
   input  logic                              word_ready,
   output logic [8*WORD_BYTES-1:0]           word_data,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              timeout_err,
   output logic                              overflow
);

   localparam int WW           = 8 * WORD_BYTES;
   // Guarded so an un-overridden CLK_RATE still elaborates far enough to report
   localparam int CLKS_PER_BIT = (CLK_RATE > 0) ? clks_per_bit(CLK_RATE, BAUD) : 2;
   localparam int TIMEOUT_CLKS = (CLK_RATE > 0) ? timeout_clks(CLK_RATE, IB_TIMEOUT) : 1;
   localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
   localparam int BCW          = $clog2(WORD_BYTES + 1);

   localparam logic [0:0] ST_IDLE    = 1'(RX_IDLE);
   localparam logic [0:0] ST_COLLECT = 1'(RX_COLLECT);

   if (CLK_RATE <= 0) begin : g_clk_rate_check
      $error("uart_rx_packet: CLK_RATE must be set to the clk frequency in MHz");
   end
   if ((WORD_BYTES < 1) || (WORD_BYTES > 8)) begin : g_word_bytes_check
      $error("uart_rx_packet: WORD_BYTES must be 1..8");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_fifo_depth_check
      $error("uart_rx_packet: FIFO_DEPTH must be a power of 2, >= 2");
   end

   logic           w_rx_dv;
   logic [7:0]     w_rx_byte;
   logic [0:0]     state_q, state_d;
   logic [BCW-1:0] cnt_q, cnt_d;
   logic [WW-1:0]  word_q, word_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           timeout_q, timeout_d;
   logic           overflow_q, overflow_d;
   logic [WW-1:0]  w_placed;
   logic           w_last_byte;
   logic           w_push;
   logic           w_pop;
   logic           w_fifo_full;

   uart_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx (
      .clk    (clk),
      .rst    (rst),
      .rx_i   (srx),
      .dv_o   (w_rx_dv),
      .byte_o (w_rx_byte)
   );

   uart_rx_fifo #(
      .WIDTH (WW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (w_push),
      .push_data_i (w_placed),
      .pop_i       (word_ready),
      .valid_o     (word_valid),
      .data_o      (word_data),
      .count_o     (fifo_count),
      .full_o      (w_fifo_full)
   );

   assign w_last_byte = (cnt_q == BCW'(WORD_BYTES - 1));
   assign w_pop       = word_valid && word_ready;
   assign timeout_err = timeout_q;
   assign overflow    = overflow_q;

   // Partial word with the incoming byte dropped into the lane for its arrival index
   always_comb begin
      w_placed = (cnt_q == '0) ? '0 : word_q;
      for (int b = 0; b < WORD_BYTES; b++) begin
         if (cnt_q == BCW'((BIG_ENDIAN != 0) ? (WORD_BYTES - 1 - b) : b))
            w_placed[b*8 +: 8] = w_rx_byte;
      end
   end

   // Assembly FSM: a byte arriving on the timeout cycle wins over the timeout
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      word_d    = word_q;
      timer_d   = timer_q;
      timeout_d = 1'b0;
      w_push    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (w_rx_dv) begin
               if (w_last_byte) begin
                  w_push = 1'b1;
                  word_d = '0;
               end else begin
                  word_d  = w_placed;
                  cnt_d   = BCW'(1);
                  state_d = ST_COLLECT;
               end
            end
         end
         default: begin
            if (w_rx_dv) begin
               timer_d = '0;
               if (w_last_byte) begin
                  w_push  = 1'b1;
                  cnt_d   = '0;
                  word_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  word_d = w_placed;
                  cnt_d  = cnt_q + BCW'(1);
               end
            end else if (timer_q == TW'(TIMEOUT_CLKS)) begin
               timeout_d = 1'b1;
               timer_d   = '0;
               cnt_d     = '0;
               word_d    = '0;
               state_d   = ST_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
      endcase
   end

   // A finished word is lost only when the FIFO is full and nothing is popped
   always_comb begin
      overflow_d = overflow_q | (w_push && w_fifo_full && !w_pop);
   end

   // Assembly, timeout and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         word_q     <= '0;
         timer_q    <= '0;
         timeout_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         word_q     <= word_d;
         timer_q    <= timer_d;
         timeout_q  <= timeout_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_packet.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_packet
//  Description : Scoreboard bench for uart_rx_packet. Three instances share
//                one serial line: A (4 bytes, big-endian), B (4 bytes,
//                little-endian), C (2 bytes, little-endian).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_packet;

   logic        clk = 1'b0;
   logic        rst;
   logic        srx;
   logic        ready_a;
   logic        valid_a, valid_b, valid_c;
   logic [31:0] data_a, data_b;
   logic [15:0] data_c;
   logic [2:0]  cnt_a, cnt_b, cnt_c;
   logic        tmo_a, tmo_b, tmo_c;
   logic        ovf_a, ovf_b, ovf_c;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] q_c[$];

   int tmo_cnt_a = 0, tmo_cnt_b = 0, tmo_cnt_c = 0;
   int tmo_gap_a = 0;
   int dv_cyc_a  = 0;
   int lat_seen  = 0;
   bit lat_en    = 1'b0;
   logic prev_valid_a = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_packet #(.CLK_RATE(10), .BAUD(1_000_000), .IB_TIMEOUT(1),
                    .WORD_BYTES(4), .BIG_ENDIAN(1), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .srx(srx), .word_valid(valid_a), .word_ready(ready_a),
      .word_data(data_a), .fifo_count(cnt_a), .timeout_err(tmo_a), .overflow(ovf_a));

   uart_rx_packet #(.CLK_RATE(10), .BAUD(1_000_000), .IB_TIMEOUT(1),
                    .WORD_BYTES(4), .BIG_ENDIAN(0), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .srx(srx), .word_valid(valid_b), .word_ready(1'b1),
      .word_data(data_b), .fifo_count(cnt_b), .timeout_err(tmo_b), .overflow(ovf_b));

   uart_rx_packet #(.CLK_RATE(10), .BAUD(1_000_000), .IB_TIMEOUT(1),
                    .WORD_BYTES(2), .BIG_ENDIAN(0), .FIFO_DEPTH(4)) dut_c (
      .clk(clk), .rst(rst), .srx(srx), .word_valid(valid_c), .word_ready(1'b1),
      .word_data(data_c), .fifo_count(cnt_c), .timeout_err(tmo_c), .overflow(ovf_c));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic sb_compare(input string name, input logic [31:0] act, input logic [31:0] exp,
                             input bit have_exp);
      checks++;
      if (!have_exp) begin
         errors++;
         $display("FAIL %s: got word 0x%0h, none expected", name, act);
      end else if (act !== exp) begin
         errors++;
         $display("FAIL %s: got word 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: samples just after the falling edge, once stimulus has settled
   always @(negedge clk) begin
      logic [31:0] e;
      #1;
      if (!rst) begin
         if (valid_a && ready_a) begin
            e = (q_a.size() != 0) ? q_a.pop_front() : 32'h0;
            sb_compare("word_a", data_a, e, q_a.size() != 0 || e != 32'h0 || 1'b0 ? 1'b1 : 1'b0);
         end
         if (valid_b) begin
            e = (q_b.size() != 0) ? q_b.pop_front() : 32'h0;
            sb_compare("word_b", data_b, e, 1'b1);
         end
         if (valid_c) begin
            e = (q_c.size() != 0) ? q_c.pop_front() : 32'h0;
            sb_compare("word_c", {16'h0, data_c}, e, 1'b1);
         end
         if (lat_en && valid_a && !prev_valid_a) begin
            lat_seen++;
            check("latency_a", 32'(cyc - dv_cyc_a), 32'd1);
         end
      end
      if (tmo_a) begin
         tmo_cnt_a++;
         tmo_gap_a = cyc - dv_cyc_a;
      end
      if (tmo_b) tmo_cnt_b++;
      if (tmo_c) tmo_cnt_c++;
      if (dut_a.w_rx_dv) dv_cyc_a = cyc;
      prev_valid_a = valid_a;
   end

   function automatic logic [7:0] pb(input int k, input int j);
      return 8'(k * 16 + j);
   endfunction

   // Serial 8N1 frame, 10 clks per bit; starts and ends on a falling edge
   task automatic send_byte(input logic [7:0] b);
      srx = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         srx = b[i];
         repeat (10) @(negedge clk);
      end
      srx = 1'b1;
      repeat (10) @(negedge clk);
   endtask

   task automatic expect_pattern(input int k, input bit to_a);
      if (to_a) q_a.push_back({pb(k,0), pb(k,1), pb(k,2), pb(k,3)});
      q_b.push_back({pb(k,3), pb(k,2), pb(k,1), pb(k,0)});
      q_c.push_back({16'h0, pb(k,1), pb(k,0)});
      q_c.push_back({16'h0, pb(k,3), pb(k,2)});
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s: words still pending a=%0d b=%0d c=%0d, expected none",
                  name, q_a.size(), q_b.size(), q_c.size());
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_valid"},   {31'h0, valid_a}, 32'h0);
      check({name, "_data"},    data_a,           32'h0);
      check({name, "_count"},   {29'h0, cnt_a},   32'h0);
      check({name, "_timeout"}, {31'h0, tmo_a},   32'h0);
      check({name, "_overflow"},{31'h0, ovf_a},   32'h0);
   endtask

   initial begin
      rst     = 1'b1;
      srx     = 1'b1;
      ready_a = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Test 1: 12 34 56 78, latency of one cycle after the last byte
      lat_en = 1'b1;
      q_a.push_back(32'h12345678);
      q_b.push_back(32'h78563412);
      q_c.push_back(32'h3412);
      q_c.push_back(32'h7856);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
      repeat (5) @(negedge clk);
      lat_en = 1'b0;
      check("latency_seen", 32'(lat_seen), 32'd1);
      wait_drain("t1_drain");

      // Test 2: AB CD EF 01 in both byte orders and 2-byte words
      q_a.push_back(32'hABCDEF01);
      q_b.push_back(32'h01EFCDAB);
      q_c.push_back(32'hCDAB);
      q_c.push_back(32'h01EF);
      send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF); send_byte(8'h01);
      wait_drain("t2_drain");

      // Test 3: partial word times out, next word is clean
      q_c.push_back(32'h3412);
      send_byte(8'h12); send_byte(8'h34);
      repeat (12000) @(negedge clk);
      check("t3_timeouts_a", 32'(tmo_cnt_a), 32'd1);
      check("t3_timeouts_b", 32'(tmo_cnt_b), 32'd1);
      check("t3_timeouts_c", 32'(tmo_cnt_c), 32'd0);
      check("t3_timeout_gap_in_range", {31'h0, (tmo_gap_a >= 9998 && tmo_gap_a <= 10006)}, 32'd1);
      q_a.push_back(32'hAABBCCDD);
      q_b.push_back(32'hDDCCBBAA);
      q_c.push_back(32'hBBAA);
      q_c.push_back(32'hDDCC);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      wait_drain("t3_drain");

      // Test 5: full FIFO, pop in the same cycle the fifth word completes
      ready_a = 1'b0;
      for (int k = 1; k <= 5; k++) expect_pattern(k, 1'b1);
      for (int k = 1; k <= 4; k++)
         for (int j = 0; j < 4; j++) send_byte(pb(k, j));
      for (int j = 0; j < 3; j++) send_byte(pb(5, j));
      check("t5_full_count", {29'h0, cnt_a}, 32'd4);
      check("t5_full_head",  data_a, 32'h10111213);
      check("t5_no_ovf_yet", {31'h0, ovf_a}, 32'd0);
      fork
         send_byte(pb(5, 3));
         begin
            int n = 0;
            while (!dut_a.w_rx_dv && n < 200) begin
               @(negedge clk);
               n++;
            end
            checks++;
            if (n >= 200) begin
               errors++;
               $display("FAIL t5_wait_dv: no byte strobe within %0d cycles, expected one", n);
            end else begin
               ready_a = 1'b1;
               @(negedge clk);
               ready_a = 1'b0;
               check("t5_count_after_push_pop", {29'h0, cnt_a}, 32'd4);
               check("t5_no_overflow",          {31'h0, ovf_a}, 32'd0);
            end
         end
      join
      ready_a = 1'b1;
      wait_drain("t5_drain");

      // Test 4: overflow drops the fifth word and sticks
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      ready_a = 1'b0;
      for (int k = 6; k <= 10; k++) expect_pattern(k, k <= 9);
      for (int k = 6; k <= 10; k++)
         for (int j = 0; j < 4; j++) send_byte(pb(k, j));
      repeat (5) @(negedge clk);
      check("t4_count",    {29'h0, cnt_a},   32'd4);
      check("t4_overflow", {31'h0, ovf_a},   32'd1);
      check("t4_valid",    {31'h0, valid_a}, 32'd1);
      check("t4_head",     data_a,           32'h60616263);
      ready_a = 1'b1;
      wait_drain("t4_drain");
      check("t4_count_empty",     {29'h0, cnt_a}, 32'd0);
      check("t4_overflow_sticky", {31'h0, ovf_a}, 32'd1);

      // Test 6: reset in the middle of a word
      q_c.push_back(32'hE2E1);
      send_byte(8'hE1); send_byte(8'hE2);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("t6_rst");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      q_a.push_back(32'h01020304);
      q_b.push_back(32'h04030201);
      q_c.push_back(32'h0201);
      q_c.push_back(32'h0403);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      wait_drain("t6_drain");

      check("final_timeouts_a", 32'(tmo_cnt_a), 32'd1);
      check("final_ovf_b",   {31'h0, ovf_b}, 32'd0);
      check("final_ovf_c",   {31'h0, ovf_c}, 32'd0);
      check("final_count_b", {29'h0, cnt_b}, 32'd0);
      check("final_count_c", {29'h0, cnt_c}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
